pingpong_counter_gen2: RTL and testbench

//  Parametrised ping-pong / wrap counter. Next generation of the lab counter with:
//   - configurable width
//   - programmable step
//   - external tick (clock-enable) input
//   - modes: ping-pong, wrap-up, wrap-down, freeze
//   - latched flip requests
//   - boundary pulse

---
 rtl/pingpong_counter_gen2_pkg.sv | 14 +
 rtl/pingpong_counter_gen2_edge_rise_det.sv | 27 ++
 rtl/pingpong_counter_gen2.sv | 111 +++++++++++
 tb/tb_pingpong_counter_gen2.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/pingpong_counter_gen2_pkg.sv
// Shared encodings for the ping-pong / wrap counter: count modes and direction values.
package pingpong_pkg;

    typedef enum logic [1:0] {
        MODE_PINGPONG = 2'b00,
        MODE_WRAPUP   = 2'b01,
        MODE_WRAPDN   = 2'b10,
        MODE_FREEZE   = 2'b11
    } mode_e;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/pingpong_counter_gen2_edge_rise_det.sv
// Rising-edge detector: one-clk pulse on a 0->1 transition of a level input.
// Combinational pulse from the current input and the previous-cycle sample.
module edge_rise_det (
    input  logic clk,
    input  logic rst_n,
    input  logic in,
    output logic pulse
);

    logic in_q;
    logic in_d;

    always_comb begin
        in_d = in;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_q <= 1'b0;
        end else begin
            in_q <= in_d;
        end
    end

    assign pulse = in & ~in_q;

endmodule

// File: rtl/pingpong_counter_gen2.sv
// Ping-pong / wrap counter advancing on tick, with latched flip requests and a boundary pulse.
// out/dir update on the edge where advance is high; at_bound is registered alongside them.
module pingpong_counter_gen2
    import pingpong_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             enable,
    input  logic             flip,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] min,
    input  logic [WIDTH-1:0] max,
    input  logic [WIDTH-1:0] step,
    output logic [WIDTH-1:0] out,
    output logic             dir,
    output logic             at_bound,
    output logic             flip_pending
);

    logic [WIDTH-1:0] out_q, out_d;
    logic             dir_q, dir_d;
    logic             at_bound_q, at_bound_d;
    logic             flip_pending_q, flip_pending_d;

    logic             flip_edge;
    logic             valid;
    logic             advance;
    logic             turn;
    logic             eff_dir;
    logic [WIDTH:0]   sum_x;
    logic [WIDTH:0]   floor_x;
    logic [WIDTH-1:0] up_val;
    logic [WIDTH-1:0] dn_val;

    edge_rise_det u_flip_det (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (flip),
        .pulse (flip_edge)
    );

    // One extra bit keeps out+step and min+step from wrapping past 2^WIDTH.
    assign sum_x   = {1'b0, out_q} + {1'b0, step};
    assign floor_x = {1'b0, min} + {1'b0, step};
    assign up_val  = (sum_x > {1'b0, max}) ? max : sum_x[WIDTH-1:0];
    assign dn_val  = ({1'b0, out_q} < floor_x) ? min : (out_q - step);

    always_comb begin
        valid          = (min < max) && (min <= out_q) && (out_q <= max) && (step != '0);
        advance        = tick && enable && valid && (mode_e'(mode) != MODE_FREEZE);
        out_d          = out_q;
        dir_d          = dir_q;
        at_bound_d     = 1'b0;
        flip_pending_d = flip_pending_q;
        turn           = (flip_pending_q || flip_edge) && (min < out_q) && (out_q < max);
        eff_dir        = dir_q ^ turn;

        if (advance) begin
            flip_pending_d = 1'b0;
            case (mode_e'(mode))
                MODE_PINGPONG: begin
                    if (eff_dir == DIR_UP && out_q == max) begin
                        eff_dir = DIR_DN;
                    end else if (eff_dir == DIR_DN && out_q == min) begin
                        eff_dir = DIR_UP;
                    end
                    out_d = (eff_dir == DIR_UP) ? up_val : dn_val;
                    dir_d = eff_dir;
                end
                MODE_WRAPUP: begin
                    out_d = (out_q == max) ? min : up_val;
                    dir_d = DIR_UP;
                end
                MODE_WRAPDN: begin
                    out_d = (out_q == min) ? max : dn_val;
                    dir_d = DIR_DN;
                end
                default: begin
                    out_d = out_q;
                    dir_d = dir_q;
                end
            endcase
            at_bound_d = (out_d == min) || (out_d == max);
        end else if (flip_edge) begin
            flip_pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q          <= min;
            dir_q          <= DIR_UP;
            at_bound_q     <= 1'b0;
            flip_pending_q <= 1'b0;
        end else begin
            out_q          <= out_d;
            dir_q          <= dir_d;
            at_bound_q     <= at_bound_d;
            flip_pending_q <= flip_pending_d;
        end
    end

    assign out          = out_q;
    assign dir          = dir_q;
    assign at_bound     = at_bound_q;
    assign flip_pending = flip_pending_q;

endmodule

// File: tb/tb_pingpong_counter_gen2.sv
// Vector-table bench for pingpong_counter_gen2 (WIDTH=4) with a one-deep expected-result queue.
module tb_pingpong_counter_gen2;

    logic       clk = 1'b0;
    logic       rst_n, tick, enable, flip;
    logic [1:0] mode;
    logic [3:0] mn, mx, st;
    logic [3:0] out;
    logic       dir, at_bound, flip_pending;

    always #5 clk = ~clk;

    pingpong_counter_gen2 #(.WIDTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick         (tick),
        .enable       (enable),
        .flip         (flip),
        .mode         (mode),
        .min          (mn),
        .max          (mx),
        .step         (st),
        .out          (out),
        .dir          (dir),
        .at_bound     (at_bound),
        .flip_pending (flip_pending)
    );

    typedef struct {
        logic       rst_n, tick, en, flip;
        logic [1:0] mode;
        logic [3:0] mn, mx, st;
        logic [3:0] eo;
        logic       ed, eab, efp;
    } vec_t;

    typedef struct {
        int         idx;
        logic [3:0] eo;
        logic       ed, eab, efp;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   vidx     = 0;

    function automatic vec_t mk(input logic r, input logic t, input logic e, input logic f,
                                input logic [1:0] m, input logic [3:0] lo, input logic [3:0] hi,
                                input logic [3:0] s, input logic [3:0] eo, input logic ed,
                                input logic eab, input logic efp);
        vec_t v;
        v.rst_n = r;  v.tick = t;  v.en = e;  v.flip = f;  v.mode = m;
        v.mn = lo;    v.mx = hi;   v.st = s;
        v.eo = eo;    v.ed = ed;   v.eab = eab; v.efp = efp;
        return v;
    endfunction

    task automatic check(input string nm, input int idx, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL v%0d %s actual=%0d expected=%0d", idx, nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        exp_t e;
        @(negedge clk);
        rst_n = v.rst_n; tick = v.tick; enable = v.en; flip = v.flip;
        mode = v.mode; mn = v.mn; mx = v.mx; st = v.st;
        e.idx = vidx; e.eo = v.eo; e.ed = v.ed; e.eab = v.eab; e.efp = v.efp;
        sb.push_back(e);
        vidx++;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty actual=0 expected=1");
        end else begin
            e = sb.pop_front();
            check("out", e.idx, out, e.eo);
            check("dir", e.idx, {3'b0, dir}, {3'b0, e.ed});
            check("at_bound", e.idx, {3'b0, at_bound}, {3'b0, e.eab});
            check("flip_pending", e.idx, {3'b0, flip_pending}, {3'b0, e.efp});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; tick = 1'b0; enable = 1'b1; flip = 1'b0;
        mode = 2'b00; mn = 4'd0; mx = 4'd0; st = 4'd0;

        // Ping-pong 2..5 step 1, reset asserted alongside tick.
        tbl.push_back(mk(0,1,1,0, 2'b00, 2,5,1,  2,1,0,0));
        tbl.push_back(mk(1,1,1,0, 2'b00, 2,5,1,  3,1,0,0));
        tbl.push_back(mk(1,1,1,0, 2'b00, 2,5,1,  4,1,0,0));
        tbl.push_back(mk(1,1,1,0, 2'b00, 2,5,1,  5,1,1,0));
        tbl.push_back(mk(1,1,1,0, 2'b00, 2,5,1,  4,0,0,0));
        tbl.push_back(mk(1,1,1,0, 2'b00, 2,5,1,  3,0,0,0));
        tbl.push_back(mk(1,1,1,0, 2'b00, 2,5,1,  2,0,1,0));
        tbl.push_back(mk(1,1,1,0, 2'b00, 2,5,1,  3,1,0,0));
        // Ping-pong 0..10 step 3: saturating steps at both ends.
        tbl.push_back(mk(0,0,1,0, 2'b00, 0,10,3, 0,1,0,0));
        tbl.push_back(mk(1,1,1,0, 2'b00, 0,10,3, 3,1,0,0));
        tbl.push_back(mk(1,1,1,0, 2'b00, 0,10,3, 6,1,0,0));
        tbl.push_back(mk(1,1,1,0, 2'b00, 0,10,3, 9,1,0,0));
        tbl.push_back(mk(1,1,1,0, 2'b00, 0,10,3, 10,1,1,0));
        tbl.push_back(mk(1,1,1,0, 2'b00, 0,10,3, 7,0,0,0));
        tbl.push_back(mk(1,1,1,0, 2'b00, 0,10,3, 4,0,0,0));
        tbl.push_back(mk(1,1,1,0, 2'b00, 0,10,3, 1,0,0,0));
        tbl.push_back(mk(1,1,1,0, 2'b00, 0,10,3, 0,0,1,0));
        tbl.push_back(mk(1,1,1,0, 2'b00, 0,10,3, 3,1,0,0));
        // Flip requests: latched, same-cycle edge, ignored at max.
        tbl.push_back(mk(0,0,1,0, 2'b00, 0,15,1, 0,1,0,0));
        for (int i = 1; i <= 6; i++)
            tbl.push_back(mk(1,1,1,0, 2'b00, 0,15,1, 4'(i),1,0,0));
        tbl.push_back(mk(1,0,1,1, 2'b00, 0,15,1, 6,1,0,1));
        tbl.push_back(mk(1,0,1,1, 2'b00, 0,15,1, 6,1,0,1));
        tbl.push_back(mk(1,1,1,1, 2'b00, 0,15,1, 5,0,0,0));
        tbl.push_back(mk(1,0,1,0, 2'b00, 0,15,1, 5,0,0,0));
        tbl.push_back(mk(1,1,1,1, 2'b00, 0,15,1, 6,1,0,0));
        tbl.push_back(mk(1,1,1,0, 2'b00, 0,15,9, 15,1,1,0));
        tbl.push_back(mk(1,0,1,1, 2'b00, 0,15,1, 15,1,0,1));
        tbl.push_back(mk(1,1,1,1, 2'b00, 0,15,1, 14,0,0,0));
        // Wrap-up, wrap-down, freeze with a flip that wrap-up then discards.
        tbl.push_back(mk(0,0,1,0, 2'b01, 1,9,4, 1,1,0,0));
        tbl.push_back(mk(1,1,1,0, 2'b01, 1,9,4, 5,1,0,0));
        tbl.push_back(mk(1,1,1,0, 2'b01, 1,9,4, 9,1,1,0));
        tbl.push_back(mk(1,1,1,0, 2'b01, 1,9,4, 1,1,1,0));
        tbl.push_back(mk(1,1,1,0, 2'b01, 1,9,4, 5,1,0,0));
        tbl.push_back(mk(1,1,1,0, 2'b10, 1,9,4, 1,0,1,0));
        tbl.push_back(mk(1,1,1,0, 2'b10, 1,9,4, 9,0,1,0));
        tbl.push_back(mk(1,1,1,0, 2'b10, 1,9,4, 5,0,0,0));
        tbl.push_back(mk(1,1,1,1, 2'b11, 1,9,4, 5,0,0,1));
        tbl.push_back(mk(1,1,1,1, 2'b01, 1,9,4, 9,1,1,0));
        // Invalid configurations and out-of-range out hold; disable holds.
        tbl.push_back(mk(0,0,1,0, 2'b00, 3,9,2, 3,1,0,0));
        tbl.push_back(mk(1,1,1,0, 2'b00, 3,9,2, 5,1,0,0));
        tbl.push_back(mk(1,1,1,0, 2'b00, 3,9,2, 7,1,0,0));
        tbl.push_back(mk(1,1,1,0, 2'b00, 7,3,2, 7,1,0,0));
        tbl.push_back(mk(1,1,1,0, 2'b00, 3,9,0, 7,1,0,0));
        tbl.push_back(mk(1,1,1,0, 2'b00, 8,12,2, 7,1,0,0));
        tbl.push_back(mk(1,1,0,0, 2'b00, 3,9,2, 7,1,0,0));
        tbl.push_back(mk(1,1,1,0, 2'b00, 3,9,2, 9,1,1,0));
        tbl.push_back(mk(1,1,1,0, 2'b00, 3,9,2, 7,0,0,0));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // Several flip edges between ticks collapse into a single direction change.
        apply(mk(0,0,1,0, 2'b00, 0,15,1, 0,1,0,0));
        apply(mk(1,1,1,0, 2'b00, 0,15,1, 1,1,0,0));
        apply(mk(1,1,1,0, 2'b00, 0,15,1, 2,1,0,0));
        apply(mk(1,0,1,1, 2'b00, 0,15,1, 2,1,0,1));
        apply(mk(1,0,1,0, 2'b00, 0,15,1, 2,1,0,1));
        apply(mk(1,0,1,1, 2'b00, 0,15,1, 2,1,0,1));
        apply(mk(1,0,1,0, 2'b00, 0,15,1, 2,1,0,1));
        apply(mk(1,1,1,0, 2'b00, 0,15,1, 1,0,0,0));

        // Reset wins over a coincident tick and flip edge mid-count.
        apply(mk(0,0,1,0, 2'b00, 2,6,1, 2,1,0,0));
        apply(mk(1,1,1,0, 2'b00, 2,6,1, 3,1,0,0));
        apply(mk(1,1,1,0, 2'b00, 2,6,1, 4,1,0,0));
        apply(mk(0,1,1,1, 2'b00, 2,6,1, 2,1,0,0));
        apply(mk(1,0,1,0, 2'b00, 2,6,1, 2,1,0,0));
        apply(mk(1,1,1,0, 2'b00, 2,6,1, 3,1,0,0));

        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_leftover actual=%0d expected=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
